prism_sp_gem_rx_single: RTL and testbench
=========================================

// Module: prism_sp_gem_rx_single
// PURPOSE
// - Receive-side counterpart of the single-core GEM TX path: takes the GEM external-FIFO RX byte
//   stream and packs it into 32-bit words for the RX core's data FIFO.
// - Emits one metadata word per accepted frame into the RX meta FIFO.
// - Admission control at SOP: a frame is written to the FIFOs in full or not at all.
// PARAMETERS
// - RX_DATA_FIFO_DEPTH  512   data FIFO depth in words; the data FIFO is 32 bits wide
// - RX_META_FIFO_DEPTH  64    meta FIFO depth in words; the meta FIFO is 64 bits wide
// - MAX_FRAME_BYTES     1536  bytes stored per frame; must be a multiple of 4; excess is truncated
// PORTS
// - clock                 in   1   single clock domain
// - resetn                in   1   asynchronous, active-low reset
// - rx_w_wr               in   1   GEM byte strobe
// - rx_w_data             in   8   GEM byte
// - rx_w_sop              in   1   first byte of frame (qualified by rx_w_wr)
// - rx_w_eop              in   1   last byte of frame (qualified by rx_w_wr)
// - rx_w_err              in   1   GEM frame error (qualified by eop)
// - rx_w_status           in   32  GEM frame status (qualified by eop)
// - rx_w_flush            in   1   GEM flush request
// - rx_w_overflow         out  1   to GEM: frame refused
// - rx_data_wr_en         out  1   data FIFO write
// - rx_data_din           out  32  packed word, little-endian byte order
// - rx_data_data_count    in   10  data FIFO occupancy
// - rx_meta_wr_en         out  1   meta FIFO write
// - rx_meta_din           out  64  {status[31:0], 14'b0, trunc, err, len[15:0]}
// - rx_meta_data_count    in   7   meta FIFO occupancy
// - stat_frames           out  32  frames written (macro-gated)
// - stat_drops            out  32  frames refused (macro-gated)
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; lane counter 0; length 0.
// - Reset mid-frame: state returns to IDLE; the remainder of the frame is ignored until the next SOP.
// - States:
//   - IDLE  wait for rx_w_wr&sop.
//   - RECV  pack bytes.
//   - DROP  discard until eop.
//   - META  write the meta word.
// - Admission at SOP in IDLE: accept when free data space (DEPTH-count) >= MAX_FRAME_BYTES/4
//   and meta count <= DEPTH-2.
//   - Accept: enter RECV; the SOP byte is lane 0.
//   - Refuse: enter DROP, pulse rx_w_overflow for 1 cycle, stat_drops++.
// - Packing: byte k goes to din[8*lane+:8].
//   - Completing lane 3: rx_data_wr_en=1 on the next cycle; no gaps required between strobes.
// - EOP byte: a partial word is zero-padded above the last lane and written next cycle (eop+1).
//   - RECV->META on that cycle; the meta word is written at eop+2; META->IDLE unconditionally.
//   - Space was reserved at SOP, so there is no FIFO full check.
// - len = bytes received (includes FCS as delivered by GEM), 16-bit, saturating at MAX_FRAME_BYTES.
// - Bytes beyond MAX_FRAME_BYTES: not written; trunc=1.
// - err = rx_w_err at eop.
// - Sop while in RECV (missing eop), or rx_w_flush in RECV:
//   - Close the frame as if eop: flush the partial word, write meta with err=1.
//   - The aborting byte is discarded; the rest of that new frame goes to DROP without an overflow pulse.
// - rx_w_flush in IDLE/DROP: go to IDLE, no writes.
// - Sop in META: treated as refused (DROP, overflow pulse, stat_drops++).
// - Single-byte frame (sop&eop): one data word {24'b0, byte}, meta len=1.
// - Eop with rx_w_wr=0 is ignored; all GEM inputs are qualified by rx_w_wr.
// - Counters wrap modulo 2^32.
// CONFIGURATION
// - Macro PRISM_SP_RX_STATS_EN:
//   - Defined: stat_frames increments on each meta write; stat_drops increments on each refusal.
//   - Undefined: both stat_* outputs are tied to 0 and no counter flops are inferred.
// TESTING
// 1. 64-byte frame 0x00..0x3F, count=0:
//    - 16 data words, first 0x03020100.
//    - Meta len=64, err=0, trunc=0, written at eop+2.
// 2. 61-byte frame: last word 0x0000003C, meta len=61.
// 3. data_count=200, depth 512 (free 312 < 384) at SOP:
//    - overflow pulses 1 cycle; no FIFO writes; stat_drops=1.
// 4. 1600-byte frame: 384 words written; meta len=1536, trunc=1.
// 5. Sop mid-frame after 10 bytes:
//    - Meta len=10, err=1; the new frame is dropped; the next clean frame is accepted.
// 6. resetn low mid-RECV:
//    - Outputs 0 asynchronously; bytes ignored until the next SOP; the next frame is correct.

Source files
------------

// File: rtl/prism_sp_gem_rx_single.sv
// GEM RX byte stream to 32-bit data FIFO words plus one 64-bit meta word per admitted frame.
// Optional frame/drop statistics counters are enabled by defining PRISM_SP_RX_STATS_EN.
module prism_sp_gem_rx_single #(
   parameter int RX_DATA_FIFO_DEPTH = 512,
   parameter int RX_META_FIFO_DEPTH = 64,
   parameter int MAX_FRAME_BYTES    = 1536
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        rx_w_wr,
   input  logic [7:0]  rx_w_data,
   input  logic        rx_w_sop,
   input  logic        rx_w_eop,
   input  logic        rx_w_err,
   input  logic [31:0] rx_w_status,
   input  logic        rx_w_flush,
   output logic        rx_w_overflow,
   output logic        rx_data_wr_en,
   output logic [31:0] rx_data_din,
   input  logic [9:0]  rx_data_data_count,
   output logic        rx_meta_wr_en,
   output logic [63:0] rx_meta_din,
   input  logic [6:0]  rx_meta_data_count,
   output logic [31:0] stat_frames,
   output logic [31:0] stat_drops
);

   localparam int          FRAME_WORDS = MAX_FRAME_BYTES / 4;
   localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_BYTES);

   typedef enum logic [1:0] {IDLE, RECV, DROP, META} state_t;

   state_t             state, state_next;
   logic [1:0]         lane, lane_next;
   logic [15:0]        len, len_next;
   logic [31:0]        word_buf, word_next;
   logic               trunc, trunc_next;
   logic               err, err_next;
   logic [31:0]        status, status_next;
   logic               data_wr_next, meta_wr_next, overflow_next;
   logic [31:0]        data_din_next;
   logic [63:0]        meta_din_next;
   logic               sop_ev, eop_ev, admit, store_ok;
   logic signed [31:0] data_free, meta_used;
   logic [31:0]        packed_word;

   assign sop_ev    = rx_w_wr & rx_w_sop;
   assign eop_ev    = rx_w_wr & rx_w_eop;
   assign data_free = RX_DATA_FIFO_DEPTH - $signed({22'b0, rx_data_data_count});
   assign meta_used = $signed({25'b0, rx_meta_data_count});
   // A whole worst-case frame must fit, so no full check is needed once admitted
   assign admit     = (data_free >= FRAME_WORDS) && (meta_used <= RX_META_FIFO_DEPTH - 2);
   assign store_ok  = (len < MAX_LEN);

   always_comb begin
      packed_word = word_buf;
      packed_word[{lane, 3'b000} +: 8] = rx_w_data;
   end

   always_comb begin
      state_next    = state;
      lane_next     = lane;
      len_next      = len;
      word_next     = word_buf;
      trunc_next    = trunc;
      err_next      = err;
      status_next   = status;
      data_wr_next  = 1'b0;
      data_din_next = rx_data_din;
      meta_wr_next  = 1'b0;
      meta_din_next = rx_meta_din;
      overflow_next = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_w_flush && sop_ev) begin
               if (admit) begin
                  len_next    = 16'd1;
                  trunc_next  = 1'b0;
                  err_next    = 1'b0;
                  status_next = '0;
                  if (eop_ev) begin
                     data_wr_next  = 1'b1;
                     data_din_next = {24'b0, rx_w_data};
                     word_next     = '0;
                     lane_next     = 2'd0;
                     err_next      = rx_w_err;
                     status_next   = rx_w_status;
                     state_next    = META;
                  end else begin
                     word_next  = {24'b0, rx_w_data};
                     lane_next  = 2'd1;
                     state_next = RECV;
                  end
               end else begin
                  overflow_next = 1'b1;
                  state_next    = eop_ev ? IDLE : DROP;
               end
            end
         end
         RECV: begin
            // Missing eop or flush: close out what we have as an errored frame
            if (rx_w_flush || sop_ev) begin
               if (lane != 2'd0) begin
                  data_wr_next  = 1'b1;
                  data_din_next = word_buf;
               end
               word_next   = '0;
               lane_next   = 2'd0;
               err_next    = 1'b1;
               status_next = '0;
               state_next  = META;
            end else if (rx_w_wr) begin
               if (store_ok) begin
                  len_next = len + 16'd1;
                  if (lane == 2'd3 || rx_w_eop) begin
                     data_wr_next  = 1'b1;
                     data_din_next = packed_word;
                     word_next     = '0;
                     lane_next     = 2'd0;
                  end else begin
                     word_next = packed_word;
                     lane_next = lane + 2'd1;
                  end
               end else begin
                  trunc_next = 1'b1;
               end
               if (rx_w_eop) begin
                  err_next    = rx_w_err;
                  status_next = rx_w_status;
                  state_next  = META;
               end
            end
         end
         META: begin
            meta_wr_next  = 1'b1;
            meta_din_next = {status, 14'b0, trunc, err, len};
            state_next    = IDLE;
            if (!rx_w_flush && sop_ev) begin
               overflow_next = 1'b1;
               if (!eop_ev) state_next = DROP;
            end
         end
         DROP: begin
            if (rx_w_flush || eop_ev) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         lane          <= 2'd0;
         len           <= 16'd0;
         word_buf      <= '0;
         trunc         <= 1'b0;
         err           <= 1'b0;
         status        <= '0;
         rx_data_wr_en <= 1'b0;
         rx_data_din   <= '0;
         rx_meta_wr_en <= 1'b0;
         rx_meta_din   <= '0;
         rx_w_overflow <= 1'b0;
      end else begin
         state         <= state_next;
         lane          <= lane_next;
         len           <= len_next;
         word_buf      <= word_next;
         trunc         <= trunc_next;
         err           <= err_next;
         status        <= status_next;
         rx_data_wr_en <= data_wr_next;
         rx_data_din   <= data_din_next;
         rx_meta_wr_en <= meta_wr_next;
         rx_meta_din   <= meta_din_next;
         rx_w_overflow <= overflow_next;
      end
   end

`ifdef PRISM_SP_RX_STATS_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stat_frames <= '0;
         stat_drops  <= '0;
      end else begin
         if (rx_meta_wr_en) stat_frames <= stat_frames + 32'd1;
         if (rx_w_overflow) stat_drops  <= stat_drops + 32'd1;
      end
   end
`else
   assign stat_frames = '0;
   assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_prism_sp_gem_rx_single.sv
// Directed bench for prism_sp_gem_rx_single: scoreboard queues of expected data/meta words
// are filled when frames are driven and drained by a monitor as the DUT writes its FIFOs.
module tb_prism_sp_gem_rx_single;

   localparam int MAX = 1536;
`ifdef PRISM_SP_RX_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetn;
   logic        rx_w_wr;
   logic [7:0]  rx_w_data;
   logic        rx_w_sop;
   logic        rx_w_eop;
   logic        rx_w_err;
   logic [31:0] rx_w_status;
   logic        rx_w_flush;
   logic        rx_w_overflow;
   logic        rx_data_wr_en;
   logic [31:0] rx_data_din;
   logic [9:0]  rx_data_data_count;
   logic        rx_meta_wr_en;
   logic [63:0] rx_meta_din;
   logic [6:0]  rx_meta_data_count;
   logic [31:0] stat_frames;
   logic [31:0] stat_drops;

   logic [31:0] data_q[$];
   logic [63:0] meta_q[$];
   int          total = 0;
   int          bad = 0;
   int          extra_data = 0;
   int          extra_meta = 0;
   int          ovf_seen = 0;
   int          ovf_exp = 0;
   int          frames_exp = 0;
   int          drops_exp = 0;
   logic [7:0]  tmp_b;

   prism_sp_gem_rx_single dut (
      .clock              (clock),
      .resetn             (resetn),
      .rx_w_wr            (rx_w_wr),
      .rx_w_data          (rx_w_data),
      .rx_w_sop           (rx_w_sop),
      .rx_w_eop           (rx_w_eop),
      .rx_w_err           (rx_w_err),
      .rx_w_status        (rx_w_status),
      .rx_w_flush         (rx_w_flush),
      .rx_w_overflow      (rx_w_overflow),
      .rx_data_wr_en      (rx_data_wr_en),
      .rx_data_din        (rx_data_din),
      .rx_data_data_count (rx_data_data_count),
      .rx_meta_wr_en      (rx_meta_wr_en),
      .rx_meta_din        (rx_meta_din),
      .rx_meta_data_count (rx_meta_data_count),
      .stat_frames        (stat_frames),
      .stat_drops         (stat_drops)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives n back-to-back bytes start, start+1, ... with optional sop on the first and eop on the last
   task automatic applyStimulus(input int n, input logic [7:0] start, input bit sop, input bit eop,
                                input bit err, input logic [31:0] status);
      for (int k = 0; k < n; k++) begin
         rx_w_wr     = 1'b1;
         rx_w_data   = start + 8'(k);
         rx_w_sop    = sop && (k == 0);
         rx_w_eop    = eop && (k == n - 1);
         rx_w_err    = err && eop && (k == n - 1);
         rx_w_status = (k == n - 1) ? status : 32'h0;
         @(posedge clock);
         #1;
      end
      rx_w_wr     = 1'b0;
      rx_w_sop    = 1'b0;
      rx_w_eop    = 1'b0;
      rx_w_err    = 1'b0;
      rx_w_status = 32'h0;
   endtask

   // Reference model of one admitted frame: stored bytes packed little-endian, then its meta word
   task automatic expectFrame(input int n, input logic [7:0] start, input bit err, input logic [31:0] status);
      int          stored;
      logic [31:0] w;
      stored = (n > MAX) ? MAX : n;
      w = '0;
      for (int k = 0; k < stored; k++) begin
         w[8*(k%4) +: 8] = start + 8'(k);
         if ((k % 4 == 3) || (k == stored - 1)) begin
            data_q.push_back(w);
            w = '0;
         end
      end
      meta_q.push_back({status, 14'b0, (n > MAX), err, 16'(stored)});
      frames_exp++;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkStats(input string tag);
      checkOutput({tag, "_frames"}, stat_frames, STATS_ON ? 32'(frames_exp) : 32'd0);
      checkOutput({tag, "_drops"}, stat_drops, STATS_ON ? 32'(drops_exp) : 32'd0);
      checkOutput({tag, "_ovf"}, 64'(ovf_seen), 64'(ovf_exp));
   endtask

   always @(negedge clock) begin
      if (rx_data_wr_en === 1'b1) begin
         if (data_q.size() > 0) checkOutput("data_word", rx_data_din, data_q.pop_front());
         else extra_data++;
      end
      if (rx_meta_wr_en === 1'b1) begin
         if (meta_q.size() > 0) checkOutput("meta_word", rx_meta_din, meta_q.pop_front());
         else extra_meta++;
      end
      if (rx_w_overflow === 1'b1) ovf_seen++;
   end

   initial begin
      resetn = 1'b0;
      rx_w_wr = 1'b0; rx_w_data = 8'h0; rx_w_sop = 1'b0; rx_w_eop = 1'b0;
      rx_w_err = 1'b0; rx_w_status = 32'h0; rx_w_flush = 1'b0;
      rx_data_data_count = 10'd0; rx_meta_data_count = 7'd0;
      idleCycles(3);
      checkOutput("rst_data_wr_en", rx_data_wr_en, 0);
      checkOutput("rst_data_din", rx_data_din, 0);
      checkOutput("rst_meta_wr_en", rx_meta_wr_en, 0);
      checkOutput("rst_meta_din", rx_meta_din, 0);
      checkOutput("rst_overflow", rx_w_overflow, 0);
      resetn = 1'b1;
      idleCycles(2);
      checkStats("rst");

      $display("[TB] 64-byte frame");
      expectFrame(64, 8'h00, 1'b0, 32'hC0DE0001);
      applyStimulus(64, 8'h00, 1'b1, 1'b1, 1'b0, 32'hC0DE0001);
      checkOutput("t1_eop1_data_wr", rx_data_wr_en, 1);
      checkOutput("t1_eop1_meta_wr", rx_meta_wr_en, 0);
      idleCycles(1);
      checkOutput("t1_eop2_meta_wr", rx_meta_wr_en, 1);
      checkOutput("t1_eop2_data_wr", rx_data_wr_en, 0);
      idleCycles(3);

      $display("[TB] 61-byte frame");
      expectFrame(61, 8'h00, 1'b0, 32'h00000002);
      applyStimulus(61, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000002);
      checkOutput("t2_last_word", rx_data_din, 32'h0000003C);
      idleCycles(3);

      $display("[TB] refusal on data FIFO space");
      rx_data_data_count = 10'd200;
      ovf_exp++; drops_exp++;
      applyStimulus(64, 8'h00, 1'b1, 1'b1, 1'b0, 32'h3);
      idleCycles(3);
      rx_data_data_count = 10'd0;
      checkStats("t3");

      $display("[TB] admission boundaries");
      for (int i = 0; i < 4; i++) begin
         rx_data_data_count = (i == 0) ? 10'd128 : (i == 1) ? 10'd129 : 10'd0;
         rx_meta_data_count = (i == 2) ? 7'd62 : (i == 3) ? 7'd63 : 7'd0;
         if (i == 0 || i == 2) expectFrame(4, 8'(16 * i), 1'b0, 32'(i));
         else begin
            ovf_exp++;
            drops_exp++;
         end
         applyStimulus(4, 8'(16 * i), 1'b1, 1'b1, 1'b0, 32'(i));
         idleCycles(3);
      end
      rx_data_data_count = 10'd0;
      rx_meta_data_count = 7'd0;
      checkStats("bound");

      $display("[TB] 1600-byte truncated frame");
      expectFrame(1600, 8'h00, 1'b0, 32'h00000044);
      applyStimulus(1600, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000044);
      idleCycles(3);

      $display("[TB] sop mid-frame");
      expectFrame(10, 8'h10, 1'b1, 32'h0);
      applyStimulus(10, 8'h10, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(8, 8'h80, 1'b1, 1'b1, 1'b0, 32'h55);
      idleCycles(3);
      expectFrame(12, 8'hA0, 1'b0, 32'h66);
      applyStimulus(12, 8'hA0, 1'b1, 1'b1, 1'b0, 32'h66);
      idleCycles(3);
      checkStats("t5");

      $display("[TB] flush mid-frame, single-byte frame, sop in META");
      expectFrame(6, 8'h20, 1'b1, 32'h0);
      applyStimulus(6, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0);
      rx_w_flush = 1'b1;
      idleCycles(1);
      rx_w_flush = 1'b0;
      idleCycles(3);
      expectFrame(1, 8'h5A, 1'b1, 32'h77);
      applyStimulus(1, 8'h5A, 1'b1, 1'b1, 1'b1, 32'h77);
      idleCycles(3);
      expectFrame(4, 8'h30, 1'b0, 32'h88);
      applyStimulus(4, 8'h30, 1'b1, 1'b1, 1'b0, 32'h88);
      ovf_exp++; drops_exp++;
      applyStimulus(4, 8'h40, 1'b1, 1'b1, 1'b0, 32'h0);
      idleCycles(3);
      checkStats("misc");

      $display("[TB] reset mid-frame");
      for (int w = 0; w < 4; w++) begin
         tmp_b = 8'h60 + 8'(4 * w);
         data_q.push_back({tmp_b + 8'd3, tmp_b + 8'd2, tmp_b + 8'd1, tmp_b});
      end
      applyStimulus(18, 8'h60, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("t6_data_din", rx_data_din, 0);
      checkOutput("t6_meta_din", rx_meta_din, 0);
      checkOutput("t6_data_wr", rx_data_wr_en, 0);
      checkOutput("t6_meta_wr", rx_meta_wr_en, 0);
      frames_exp = 0;
      drops_exp = 0;
      checkOutput("t6_stat_frames", stat_frames, 0);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      applyStimulus(6, 8'h72, 1'b0, 1'b1, 1'b0, 32'h99);
      idleCycles(3);
      expectFrame(9, 8'hB0, 1'b0, 32'hAB);
      applyStimulus(9, 8'hB0, 1'b1, 1'b1, 1'b0, 32'hAB);
      idleCycles(3);
      checkStats("t6");

      checkOutput("data_extra", 64'(extra_data), 0);
      checkOutput("meta_extra", 64'(extra_meta), 0);
      checkOutput("data_q_left", 64'(data_q.size()), 0);
      checkOutput("meta_q_left", 64'(meta_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
